// File: rtl/gate_sequence_controller_pkg.sv
// Shared types and constants for the gate-sequence folding controller.
// A complex 2x2 matrix is packed as [row][col][re=0/im=1] fixed-point words.
package gate_sequence_controller_pkg;

   localparam int unsigned WIDTH     = 37;
   localparam int unsigned FRAC_BITS = 32;

   localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;

   typedef logic signed [1:0][1:0][1:0][WIDTH-1:0] cmatrix_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      FLUSH,
      DONE
   } state_t;

   function automatic cmatrix_t identity_mtx();
      cmatrix_t m;
      m          = '0;
      m[0][0][0] = ONE;
      m[1][1][0] = ONE;
      return m;
   endfunction

endpackage

// File: rtl/gate_sequence_controller.sv
// Folds a stream of 2x2 complex gates into one accumulated unitary (ACC <= G x ACC)
// by sequencing an external complex matrix multiplier one gate at a time.
module gate_sequence_controller
   import gate_sequence_controller_pkg::*;
#(
   parameter int unsigned COUNT_W = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               abort,
   input  logic               gate_valid,
   output logic               gate_ready,
   input  cmatrix_t           gate_mtx,
   input  logic               gate_last,
   output cmatrix_t           mul_a,
   output cmatrix_t           mul_b,
   output logic               mul_start,
   output logic               mul_reset,
   input  cmatrix_t           mul_r,
   input  logic               mul_done,
   output logic               res_valid,
   input  logic               res_ready,
   output cmatrix_t           res_mtx,
   output logic [COUNT_W-1:0] res_count,
   output logic               err_timeout
);

   localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   state_t               state;
   cmatrix_t             acc;
   cmatrix_t             g_reg;
   logic                 last_reg;
   logic [COUNT_W-1:0]   count;
   logic [TIMER_W-1:0]   timer;
   logic                 flush_cnt;

   // The multiplier samples its inputs every clock, so both operands come
   // straight from registers that only move on accept or on completion.
   assign mul_a     = g_reg;
   assign mul_b     = acc;
   assign res_mtx   = acc;
   assign res_count = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         acc         <= identity_mtx();
         g_reg       <= '0;
         last_reg    <= 1'b0;
         count       <= '0;
         timer       <= '0;
         flush_cnt   <= 1'b0;
         gate_ready  <= 1'b1;
         mul_start   <= 1'b0;
         mul_reset   <= 1'b0;
         res_valid   <= 1'b0;
         err_timeout <= 1'b0;
      end else if (abort) begin
         // Abort outranks every other event, including a result awaiting pickup.
         state      <= FLUSH;
         flush_cnt  <= 1'b0;
         mul_reset  <= 1'b1;
         mul_start  <= 1'b0;
         gate_ready <= 1'b0;
         res_valid  <= 1'b0;
         acc        <= identity_mtx();
         count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gate_valid) begin
                  g_reg      <= gate_mtx;
                  last_reg   <= gate_last;
                  gate_ready <= 1'b0;
                  mul_start  <= 1'b1;
                  state      <= START;
                  if (count == '0) begin
                     err_timeout <= 1'b0;
                  end
                  if (count != COUNT_MAX) begin
                     count <= count + COUNT_W'(1);
                  end
               end
            end

            START: begin
               mul_start <= 1'b0;
               timer     <= '0;
               state     <= WAIT;
            end

            WAIT: begin
               if (mul_done) begin
                  acc <= mul_r;
                  if (last_reg) begin
                     res_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     gate_ready <= 1'b1;
                     state      <= IDLE;
                  end
               end else if (timer == TIMER_LAST) begin
                  err_timeout <= 1'b1;
                  mul_reset   <= 1'b1;
                  flush_cnt   <= 1'b0;
                  acc         <= identity_mtx();
                  count       <= '0;
                  state       <= FLUSH;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            // mul_reset is held for exactly two cycles before returning to IDLE.
            FLUSH: begin
               if (flush_cnt) begin
                  mul_reset  <= 1'b0;
                  gate_ready <= 1'b1;
                  state      <= IDLE;
               end else begin
                  flush_cnt <= 1'b1;
               end
            end

            DONE: begin
               if (res_ready) begin
                  res_valid  <= 1'b0;
                  acc        <= identity_mtx();
                  count      <= '0;
                  gate_ready <= 1'b1;
                  state      <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
